snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_if.sv | 37 +++
 rtl/snoop_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_if.sv
// Snoop bus bundle: core requests, snoop responses and memory handshake on one side,
// arbiter grants and strobes on the other.
interface snoop_bus_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 13
);
    localparam int IDX_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]        req_rd;
    logic [NUM_CORES-1:0]        req_wr;
    logic [NUM_CORES-1:0]        req_inv;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES-1:0]        snoop_hit;
    logic [2*NUM_CORES-1:0]      snoop_state;
    logic                        mem_rdy;

    logic [NUM_CORES-1:0]        grant;
    logic [ADDR_W-1:0]           bus_addr;
    logic [NUM_CORES-1:0]        snoop;
    logic [NUM_CORES-1:0]        inv;
    logic                        fwd_valid;
    logic [IDX_W-1:0]            fwd_src;
    logic                        mem_re;
    logic                        mem_we;
    logic [NUM_CORES-1:0]        done;
    logic                        err;

    modport master (
        input  req_rd, req_wr, req_inv, req_addr, snoop_hit, snoop_state, mem_rdy,
        output grant, bus_addr, snoop, inv, fwd_valid, fwd_src, mem_re, mem_we, done, err
    );

    modport slave (
        output req_rd, req_wr, req_inv, req_addr, snoop_hit, snoop_state, mem_rdy,
        input  grant, bus_addr, snoop, inv, fwd_valid, fwd_src, mem_re, mem_we, done, err
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter: one transaction at a time, snoop/forward/memory/invalidate.
// Define SNOOP_BUS_TIMEOUT_EN to abort MEM_WAIT after MEM_TIMEOUT cycles with a sticky err.
module snoop_bus_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_W      = 13,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    snoop_bus_if.master bus
);
    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [2:0] {IDLE, SNOOP, FWD, MEM_WAIT, INV, DONE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, owner, sup_q;
    logic                 op_wr, sup_mod_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [NUM_CORES-1:0] any_req, owner_oh, hit_vec;
    logic                 win_found, sup_found, sup_mod, tmo;
    logic [IDX_W-1:0]     win_idx, sup_idx, cand_idx;
    logic [IDX_W:0]       cand;

    if (NUM_CORES < 2 || NUM_CORES > 8 || MEM_TIMEOUT < 1) begin : g_param_check
        $error("snoop_bus_arbiter: parameter out of range");
    end

    assign any_req = bus.req_rd | bus.req_wr | bus.req_inv;

    // Scan upward from the core just above the last owner, wrapping once.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_CORES)) cand = cand - (IDX_W+1)'(NUM_CORES);
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && any_req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        hit_vec         = '0;
        for (int i = 0; i < NUM_CORES; i++)
            hit_vec[i] = bus.snoop_hit[i] && (bus.snoop_state[2*i +: 2] != 2'b00) && !owner_oh[i];
        sup_found = 1'b0;
        sup_idx   = '0;
        sup_mod   = 1'b0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sup_found = 1'b1;
                sup_idx   = IDX_W'(i);
                sup_mod   = (bus.snoop_state[2*i +: 2] == 2'b10);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.grant     = (state == IDLE) ? '0 : owner_oh;
        bus.snoop     = '0;
        bus.inv       = '0;
        bus.done      = '0;
        bus.fwd_valid = 1'b0;
        bus.fwd_src   = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        case (state)
            IDLE: if (win_found) state_nxt = bus.req_inv[win_idx] ? INV : SNOOP;
            SNOOP: begin
                bus.snoop = ~owner_oh;
                if (op_wr) bus.inv = hit_vec;
                // A write only uses the forward path when a dirty copy must come back.
                if (sup_found && (!op_wr || sup_mod)) state_nxt = FWD;
                else                                  state_nxt = MEM_WAIT;
            end
            FWD: begin
                bus.fwd_valid = 1'b1;
                bus.fwd_src   = sup_q;
                bus.mem_we    = sup_mod_q;
                state_nxt     = DONE;
            end
            MEM_WAIT: begin
                bus.mem_re = 1'b1;
                if (bus.mem_rdy || tmo) state_nxt = DONE;
            end
            INV: begin
                bus.inv   = ~owner_oh;
                state_nxt = DONE;
            end
            DONE: begin
                bus.done  = owner_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(NUM_CORES-1);
            owner     <= '0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            sup_q     <= '0;
            sup_mod_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_found) begin
                owner  <= win_idx;
                op_wr  <= bus.req_wr[win_idx];
                addr_q <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            end
            if (state == SNOOP) begin
                sup_q     <= sup_idx;
                sup_mod_q <= sup_mod;
            end
            if (state == DONE) rr_ptr <= owner;
        end
    end

    assign bus.bus_addr = addr_q;

`ifdef SNOOP_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign tmo     = (state == MEM_WAIT) && !bus.mem_rdy && (cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state == MEM_WAIT && state_nxt == MEM_WAIT) ? cnt + 1'b1 : '0;
            err_q <= err_q | tmo;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a transaction-level expectation queue checked on every
// negedge, plus literal checks of the headline scenarios. Timeout cases need SNOOP_BUS_TIMEOUT_EN.
module tb_snoop_bus_arbiter;
    localparam int NC  = 4;
    localparam int AW  = 13;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mem_lat  = 1;
    int   mcnt     = 0;

    snoop_bus_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus ();

    snoop_bus_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] grant, snoop, inv, done;
        logic          fwd_valid, mem_re, mem_we, err;
        logic [1:0]    fwd_src;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            m_rr   = NC - 1;
    logic [AW-1:0] m_addr = '0;
    logic          m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t blank(logic [NC-1:0] g, logic [AW-1:0] a, logic er);
        exp_t r;
        r.grant = g;    r.snoop = '0;  r.inv = '0;    r.done = '0;
        r.fwd_valid = 0; r.mem_re = 0; r.mem_we = 0;  r.err = er;
        r.fwd_src = '0; r.addr = a;
        return r;
    endfunction

    // Expand one whole transaction into its expected per-cycle outputs.
    task automatic build_txn();
        logic [NC-1:0] reqs, g, hits;
        logic [AW-1:0] a;
        logic          is_inv, is_wr, smod, terr;
        int            w, sup, nmw, c;
        exp_t          r;
        reqs = bus.req_rd | bus.req_wr | bus.req_inv;
        w = -1;
        for (int k = 1; k <= NC; k++) begin
            c = (m_rr + k) % NC;
            if (w < 0 && ((reqs >> c) & NC'(1)) != 0) w = c;
        end
        g      = NC'(1) << w;
        a      = bus.req_addr[w*AW +: AW];
        is_inv = (bus.req_inv & g) != 0;
        is_wr  = (bus.req_wr & g) != 0;
        hits   = '0;
        sup    = -1;
        smod   = 1'b0;
        terr   = 1'b0;
        for (int i = NC-1; i >= 0; i--) begin
            if (i != w && bus.snoop_hit[i] && bus.snoop_state[2*i +: 2] != 2'b00) begin
                hits[i] = 1'b1;
                sup     = i;
                smod    = (bus.snoop_state[2*i +: 2] == 2'b10);
            end
        end
        if (is_inv) begin
            r = blank(g, a, m_err); r.inv = ~g; q.push_back(r);
        end else begin
            r = blank(g, a, m_err); r.snoop = ~g;
            if (is_wr) r.inv = hits;
            q.push_back(r);
            if (sup >= 0 && (!is_wr || smod)) begin
                r = blank(g, a, m_err); r.fwd_valid = 1'b1; r.fwd_src = sup[1:0]; r.mem_we = smod;
                q.push_back(r);
            end else begin
                nmw = (mem_lat > 0) ? mem_lat : 64;
`ifdef SNOOP_BUS_TIMEOUT_EN
                if (mem_lat == 0 || mem_lat > TMO) begin nmw = TMO; terr = 1'b1; end
`endif
                repeat (nmw) begin r = blank(g, a, m_err); r.mem_re = 1'b1; q.push_back(r); end
            end
        end
        r = blank(g, a, m_err | terr); r.done = g; q.push_back(r);
        m_rr = w;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete(); m_rr = NC - 1; m_addr = '0; m_err = 1'b0;
            e = blank('0, m_addr, m_err);
        end else if (q.size() == 0) begin
            e = blank('0, m_addr, m_err);
            if ((bus.req_rd | bus.req_wr | bus.req_inv) != 0) build_txn();
        end else begin
            e = q.pop_front(); m_addr = e.addr; m_err = e.err;
        end
        chk("cyc_grant", bus.grant, e.grant);
        chk("cyc_snoop", bus.snoop, e.snoop);
        chk("cyc_inv", bus.inv, e.inv);
        chk("cyc_done", bus.done, e.done);
        chk("cyc_fwd_valid", bus.fwd_valid, e.fwd_valid);
        if (e.fwd_valid) chk("cyc_fwd_src", bus.fwd_src, e.fwd_src);
        chk("cyc_mem_re", bus.mem_re, e.mem_re);
        chk("cyc_mem_we", bus.mem_we, e.mem_we);
        chk("cyc_err", bus.err, e.err);
        chk("cyc_bus_addr", bus.bus_addr, e.addr);
    end

    // Memory responder: mem_rdy on the mem_lat-th mem_re cycle; mem_lat 0 means never.
    always @(posedge clk) begin
        #2;
        if (bus.mem_re) begin
            mcnt++;
            bus.mem_rdy = (mem_lat != 0) && (mcnt == mem_lat);
        end else begin
            mcnt = 0;
            bus.mem_rdy = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_reqs();
        bus.req_rd = '0; bus.req_wr = '0; bus.req_inv = '0;
    endtask

    task automatic run_to_done(output int n_re, output int n_fwd, output int n_snp);
        n_re = 0; n_fwd = 0; n_snp = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.mem_re) n_re++;
            if (bus.fwd_valid) n_fwd++;
            if (bus.snoop != 0) n_snp++;
            if (bus.done != 0) break;
        end
    endtask

    int n_re, n_fwd, n_snp;
    int order[$];
    int exp_ord[5];
    logic [NC-1:0] prev_g;

    initial begin
        rst = 1'b0;
        clear_reqs();
        bus.req_addr = '0; bus.snoop_hit = '0; bus.snoop_state = '0;
        #1 rst = 1'b1;
        step(); step();
        chk("reset_grant", bus.grant, 4'b0000);
        chk("reset_bus_addr", bus.bus_addr, 13'h0);
        chk("reset_err", bus.err, 1'b0);
        rst = 1'b0;
        step();

        // Read miss, no sharers, memory answers on third cycle.
        mem_lat = 3;
        bus.req_addr[2*AW +: AW] = 13'h0A5;
        bus.req_rd = 4'b0100;
        step();
        chk("t1_grant", bus.grant, 4'b0100);
        chk("t1_snoop", bus.snoop, 4'b1011);
        chk("t1_bus_addr", bus.bus_addr, 13'h0A5);
        clear_reqs();
        run_to_done(n_re, n_fwd, n_snp);
        chk("t1_mem_re_cycles", n_re, 3);
        chk("t1_snoop_once", n_snp, 0);
        chk("t1_done", bus.done, 4'b0100);
        step();
        chk("t1_idle_grant", bus.grant, 4'b0000);
        chk("t1_idle_addr_held", bus.bus_addr, 13'h0A5);

        // Read miss, modified copy in core 3; owner's own hit must be ignored.
        bus.snoop_hit = 4'b1001; bus.snoop_state = 8'b10_00_00_01;
        bus.req_addr[0 +: AW] = 13'h1FFF;
        bus.req_rd = 4'b0001;
        step();
        chk("t2_snoop", bus.snoop, 4'b1110);
        clear_reqs();
        step();
        chk("t2_fwd_valid", bus.fwd_valid, 1'b1);
        chk("t2_fwd_src", bus.fwd_src, 2'd3);
        chk("t2_mem_we", bus.mem_we, 1'b1);
        step();
        chk("t2_done", bus.done, 4'b0001);
        step();

        // Write miss, shared copies in cores 0 and 2.
        mem_lat = 2;
        bus.snoop_hit = 4'b0101; bus.snoop_state = 8'b00_01_00_01;
        bus.req_addr[1*AW +: AW] = 13'h0333;
        bus.req_wr = 4'b0010;
        step();
        chk("t3_inv", bus.inv, 4'b0101);
        chk("t3_snoop", bus.snoop, 4'b1101);
        clear_reqs();
        run_to_done(n_re, n_fwd, n_snp);
        chk("t3_mem_re_cycles", n_re, 2);
        chk("t3_no_fwd", n_fwd, 0);
        chk("t3_done", bus.done, 4'b0010);
        step();

        // Upgrade beats rd/wr of the same core; core 2 wins round robin over core 0.
        bus.snoop_hit = '0; bus.snoop_state = '0;
        bus.req_rd = 4'b0101; bus.req_wr = 4'b0100; bus.req_inv = 4'b0100;
        step();
        chk("t4_grant", bus.grant, 4'b0100);
        chk("t4_inv", bus.inv, 4'b1011);
        chk("t4_no_snoop", bus.snoop, 4'b0000);
        clear_reqs();
        step();
        chk("t4_done", bus.done, 4'b0100);
        step();

        // Write miss: lowest hitter is shared, so memory path despite a modified core 1.
        mem_lat = 1;
        bus.snoop_hit = 4'b0011; bus.snoop_state = 8'b00_00_10_01;
        bus.req_wr = 4'b1000;
        step();
        chk("t5_inv", bus.inv, 4'b0011);
        clear_reqs();
        step();
        chk("t5_mem_re", bus.mem_re, 1'b1);
        chk("t5_no_fwd", bus.fwd_valid, 1'b0);
        step();
        chk("t5_done", bus.done, 4'b1000);
        step();

        // Read miss served by a shared copy: forward without writeback.
        bus.snoop_hit = 4'b0100; bus.snoop_state = 8'b00_01_00_00;
        bus.req_rd = 4'b0010;
        step();
        clear_reqs();
        step();
        chk("t6_fwd_src", bus.fwd_src, 2'd2);
        chk("t6_mem_we", bus.mem_we, 1'b0);
        step(); step();

        // All cores reading continuously from reset: strict rotation.
        bus.snoop_hit = '0; bus.snoop_state = '0; mem_lat = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_rd = 4'b1111;
        prev_g = '0;
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            step();
            if (bus.grant != 0 && prev_g == 0)
                for (int j = 0; j < NC; j++) if (bus.grant[j]) order.push_back(j);
            prev_g = bus.grant;
        end
        exp_ord = '{0, 1, 2, 3, 0};
        chk("t7_grant_count", order.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) chk("t7_grant_order", order[k], exp_ord[k]);
        clear_reqs();
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.grant == 0) break;
        end
        step();

        // Memory never answers.
        mem_lat = 0;
`ifdef SNOOP_BUS_TIMEOUT_EN
        bus.req_rd = 4'b0010;
        step();
        clear_reqs();
        run_to_done(n_re, n_fwd, n_snp);
        chk("t8_timeout_cycles", n_re, TMO);
        chk("t8_done", bus.done, 4'b0010);
        chk("t8_err", bus.err, 1'b1);
        step();
        chk("t8_err_sticky", bus.err, 1'b1);
`endif
        bus.req_rd = 4'b0010;
        step();
        clear_reqs();
        repeat (5) step();
        chk("t8_in_mem_wait", bus.mem_re, 1'b1);
        rst = 1'b1;
        #1;
        chk("t8_rst_grant", bus.grant, 4'b0000);
        chk("t8_rst_mem_re", bus.mem_re, 1'b0);
        chk("t8_rst_strobes", {bus.snoop, bus.inv, bus.done}, 12'h000);
        chk("t8_rst_fwd_we", {bus.fwd_valid, bus.mem_we}, 2'b00);
        chk("t8_rst_bus_addr", bus.bus_addr, 13'h0);
        chk("t8_rst_err", bus.err, 1'b0);
        step();
        rst = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
